// File: rtl/cap_board_pkg.sv
// Shared definitions for the capacitor-bank push-pull driver: parameter
// defaults, the minimum half period and the phase FSM encoding.
package cap_board_pkg;

  localparam int N_BANKS_DEF     = 4;
  localparam int DIV_W_DEF       = 8;
  localparam int DEAD_W_DEF      = 4;
  localparam int MIN_HALF_PERIOD = 2;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_DEAD_A  = 3'd1;
  localparam logic [2:0] S_DRIVE_A = 3'd2;
  localparam logic [2:0] S_DEAD_B  = 3'd3;
  localparam logic [2:0] S_DRIVE_B = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE    = S_IDLE,
    ST_DEAD_A  = S_DEAD_A,
    ST_DRIVE_A = S_DRIVE_A,
    ST_DEAD_B  = S_DEAD_B,
    ST_DRIVE_B = S_DRIVE_B
  } phase_state_t;

endpackage

// File: rtl/cap_bank_pushpull_driver_timer.sv
// Sub-state duration timer: a down-counter loaded with either the dead time
// or the drive time (H - Deff) and flagging the last cycle of the sub-state.
module cap_phase_timer #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_sel_dead,
  input  logic [DIV_W-1:0] i_h,
  input  logic [DIV_W-1:0] i_d,
  output logic             o_last
);

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] w_len;

  // Pick the length of the sub-state about to start.
  always_comb begin
    if (i_sel_dead) begin
      w_len = i_d;
    end else begin
      w_len = i_h - i_d;
    end
  end

  // Count remaining cycles of the current sub-state, reloading on transitions.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= w_len;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - ONE;
    end
  end

  // The counter holds the cycles left including the current one.
  assign o_last = (r_cnt <= ONE);

endmodule

// File: rtl/cap_bank_pushpull_driver.sv
// Push-pull gate drive for N capacitor banks. Bank mask, half period and
// dead time are latched only at period start so every transformer sees
// whole, volt-second-balanced periods of exactly 2*H clock cycles.
module cap_bank_pushpull_driver
  import cap_board_pkg::*;
#(
  parameter int N_BANKS = N_BANKS_DEF,
  parameter int DIV_W   = DIV_W_DEF,
  parameter int DEAD_W  = DEAD_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [N_BANKS-1:0]   state,
  input  logic [DIV_W-1:0]     half_period,
  input  logic [DEAD_W-1:0]    dead_time,
  output logic [2*N_BANKS-1:0] fets,
  output logic [N_BANKS-1:0]   active_state,
  output logic                 running,
  output logic                 period_start
);

  localparam logic [DIV_W-1:0] ONE    = DIV_W'(1);
  localparam logic [DIV_W-1:0] MIN_HP = DIV_W'(MIN_HALF_PERIOD);

  phase_state_t         r_st;
  logic [DIV_W-1:0]     r_h;
  logic [DIV_W-1:0]     r_d;
  logic [N_BANKS-1:0]   r_active;
  logic [2*N_BANKS-1:0] r_fets;
  logic                 r_running;
  logic                 r_period_start;

  phase_state_t         w_nxt_st;
  logic                 w_start;
  logic                 w_load;
  logic                 w_sel_dead;
  logic                 w_last;
  logic [DIV_W-1:0]     w_h_new;
  logic [DIV_W-1:0]     w_d_ext;
  logic [DIV_W-1:0]     w_d_new;
  logic [DIV_W-1:0]     w_h_use;
  logic [DIV_W-1:0]     w_d_use;
  logic [N_BANKS-1:0]   w_act_nxt;
  logic [2*N_BANKS-1:0] w_fets_nxt;

  // Clamp the live timing inputs: H >= 2, dead time <= H - 1.
  always_comb begin
    w_d_ext = DIV_W'(dead_time);
    if (half_period < MIN_HP) begin
      w_h_new = MIN_HP;
    end else begin
      w_h_new = half_period;
    end
    if (w_d_ext > (w_h_new - ONE)) begin
      w_d_new = w_h_new - ONE;
    end else begin
      w_d_new = w_d_ext;
    end
  end

  // Phase sequencing: next state, period-start decision and timer reload.
  always_comb begin
    w_nxt_st   = r_st;
    w_start    = 1'b0;
    w_load     = 1'b0;
    w_sel_dead = 1'b0;
    case (r_st)
      ST_IDLE: begin
        if (enable) begin
          w_start    = 1'b1;
          w_load     = 1'b1;
          w_sel_dead = (w_d_new != '0);
          w_nxt_st   = (w_d_new != '0) ? ST_DEAD_A : ST_DRIVE_A;
        end else begin
          w_nxt_st = ST_IDLE;
        end
      end
      ST_DEAD_A: begin
        if (w_last) begin
          w_load   = 1'b1;
          w_nxt_st = ST_DRIVE_A;
        end else begin
          w_nxt_st = ST_DEAD_A;
        end
      end
      ST_DRIVE_A: begin
        if (w_last) begin
          w_load     = 1'b1;
          w_sel_dead = (r_d != '0);
          w_nxt_st   = (r_d != '0) ? ST_DEAD_B : ST_DRIVE_B;
        end else begin
          w_nxt_st = ST_DRIVE_A;
        end
      end
      ST_DEAD_B: begin
        if (w_last) begin
          w_load   = 1'b1;
          w_nxt_st = ST_DRIVE_B;
        end else begin
          w_nxt_st = ST_DEAD_B;
        end
      end
      ST_DRIVE_B: begin
        if (w_last && enable) begin
          w_start    = 1'b1;
          w_load     = 1'b1;
          w_sel_dead = (w_d_new != '0);
          w_nxt_st   = (w_d_new != '0) ? ST_DEAD_A : ST_DRIVE_A;
        end else if (w_last) begin
          w_nxt_st = ST_IDLE;
        end else begin
          w_nxt_st = ST_DRIVE_B;
        end
      end
      default: begin
        w_nxt_st = ST_IDLE;
      end
    endcase
  end

  // A new period times its first sub-state from the freshly clamped inputs.
  always_comb begin
    if (w_start) begin
      w_h_use = w_h_new;
      w_d_use = w_d_new;
    end else begin
      w_h_use = r_h;
      w_d_use = r_d;
    end
  end

  // Next-cycle bank mask and gate pattern; phases A and B never overlap.
  always_comb begin
    if (w_start) begin
      w_act_nxt = state;
    end else if (w_nxt_st == ST_IDLE) begin
      w_act_nxt = '0;
    end else begin
      w_act_nxt = r_active;
    end
    case (w_nxt_st)
      ST_DRIVE_A: w_fets_nxt = {{N_BANKS{1'b0}}, w_act_nxt};
      ST_DRIVE_B: w_fets_nxt = {w_act_nxt, {N_BANKS{1'b0}}};
      default:    w_fets_nxt = '0;
    endcase
  end

  cap_phase_timer #(
    .DIV_W(DIV_W)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_load),
    .i_sel_dead(w_sel_dead),
    .i_h       (w_h_use),
    .i_d       (w_d_use),
    .o_last    (w_last)
  );

  // FSM state, period latches and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_st           <= ST_IDLE;
      r_h            <= '0;
      r_d            <= '0;
      r_active       <= '0;
      r_fets         <= '0;
      r_running      <= 1'b0;
      r_period_start <= 1'b0;
    end else begin
      r_st           <= w_nxt_st;
      r_active       <= w_act_nxt;
      r_fets         <= w_fets_nxt;
      r_running      <= (w_nxt_st != ST_IDLE);
      r_period_start <= w_start;
      if (w_start) begin
        r_h <= w_h_new;
        r_d <= w_d_new;
      end
    end
  end

  assign fets         = r_fets;
  assign active_state = r_active;
  assign running      = r_running;
  assign period_start = r_period_start;

endmodule

// File: tb/tb_cap_bank_pushpull_driver.sv
// Directed vector table plus a random soak for cap_bank_pushpull_driver.
module tb_cap_bank_pushpull_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [3:0] state;
  logic [7:0] half_period;
  logic [3:0] dead_time;
  logic [7:0] fets;
  logic [3:0] active_state;
  logic       running;
  logic       period_start;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       r;
    logic       en;
    logic [3:0] st;
    logic [7:0] hp;
    logic [3:0] dt;
    logic [7:0] f;
    logic [3:0] a;
    logic       run;
    logic       ps;
  } vec_t;

  vec_t vec[200];
  int   nvec = 0;

  cap_bank_pushpull_driver #(
    .N_BANKS(4),
    .DIV_W  (8),
    .DEAD_W (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .state       (state),
    .half_period (half_period),
    .dead_time   (dead_time),
    .fets        (fets),
    .active_state(active_state),
    .running     (running),
    .period_start(period_start)
  );

  always #5 clk = ~clk;

  task automatic add(input int n, input logic r, input logic en, input logic [3:0] st,
                     input logic [7:0] hp, input logic [3:0] dt, input logic [7:0] f,
                     input logic [3:0] a, input logic run, input logic ps);
    for (int k = 0; k < n; k++) begin
      vec[nvec] = '{r, en, st, hp, dt, f, a, run, ps};
      nvec++;
    end
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  initial begin
    int cnt;
    int hlat;
    bit in_period;
    int hv;

    rst = 1'b1; enable = 1'b0; state = 4'h0; half_period = 8'd10; dead_time = 4'd2;

    // Reset held with enable and all banks requested
    add(3, 1'b1, 1'b1, 4'hF, 8'd10, 4'd2, 8'h00, 4'h0, 1'b0, 1'b0);
    // Period 1: H=10 D=2 state=0101
    add(1, 1'b0, 1'b1, 4'h5, 8'd10, 4'd2, 8'h00, 4'h5, 1'b1, 1'b1);
    add(1, 1'b0, 1'b1, 4'h5, 8'd10, 4'd2, 8'h00, 4'h5, 1'b1, 1'b0);
    add(8, 1'b0, 1'b1, 4'h5, 8'd10, 4'd2, 8'h05, 4'h5, 1'b1, 1'b0);
    add(2, 1'b0, 1'b1, 4'h5, 8'd10, 4'd2, 8'h00, 4'h5, 1'b1, 1'b0);
    add(8, 1'b0, 1'b1, 4'h5, 8'd10, 4'd2, 8'h50, 4'h5, 1'b1, 1'b0);
    // Period 2: state changes to 0011 at cycle 5, ignored until next period
    add(1, 1'b0, 1'b1, 4'h5, 8'd10, 4'd2, 8'h00, 4'h5, 1'b1, 1'b1);
    add(1, 1'b0, 1'b1, 4'h5, 8'd10, 4'd2, 8'h00, 4'h5, 1'b1, 1'b0);
    add(2, 1'b0, 1'b1, 4'h5, 8'd10, 4'd2, 8'h05, 4'h5, 1'b1, 1'b0);
    add(6, 1'b0, 1'b1, 4'h3, 8'd10, 4'd2, 8'h05, 4'h5, 1'b1, 1'b0);
    add(2, 1'b0, 1'b1, 4'h3, 8'd10, 4'd2, 8'h00, 4'h5, 1'b1, 1'b0);
    add(8, 1'b0, 1'b1, 4'h3, 8'd10, 4'd2, 8'h50, 4'h5, 1'b1, 1'b0);
    // Period 3: new mask, enable dropped during DRIVE_A, period completes
    add(1, 1'b0, 1'b1, 4'h3, 8'd10, 4'd2, 8'h00, 4'h3, 1'b1, 1'b1);
    add(1, 1'b0, 1'b1, 4'h3, 8'd10, 4'd2, 8'h00, 4'h3, 1'b1, 1'b0);
    add(3, 1'b0, 1'b1, 4'h3, 8'd10, 4'd2, 8'h03, 4'h3, 1'b1, 1'b0);
    add(5, 1'b0, 1'b0, 4'h3, 8'd10, 4'd2, 8'h03, 4'h3, 1'b1, 1'b0);
    add(2, 1'b0, 1'b0, 4'h3, 8'd10, 4'd2, 8'h00, 4'h3, 1'b1, 1'b0);
    add(8, 1'b0, 1'b0, 4'h3, 8'd10, 4'd2, 8'h30, 4'h3, 1'b1, 1'b0);
    add(2, 1'b0, 1'b0, 4'h3, 8'd10, 4'd2, 8'h00, 4'h0, 1'b0, 1'b0);
    // Clamping: half_period=1, dead_time=15 -> H=2, Deff=1
    for (int p = 0; p < 2; p++) begin
      add(1, 1'b0, 1'b1, 4'h9, 8'd1, 4'd15, 8'h00, 4'h9, 1'b1, 1'b1);
      add(1, 1'b0, 1'b1, 4'h9, 8'd1, 4'd15, 8'h09, 4'h9, 1'b1, 1'b0);
      add(1, 1'b0, 1'b1, 4'h9, 8'd1, 4'd15, 8'h00, 4'h9, 1'b1, 1'b0);
      add(1, 1'b0, 1'b1, 4'h9, 8'd1, 4'd15, 8'h90, 4'h9, 1'b1, 1'b0);
    end
    // No dead time: H=6, D=0
    add(1, 1'b0, 1'b1, 4'hC, 8'd6, 4'd0, 8'h0C, 4'hC, 1'b1, 1'b1);
    add(5, 1'b0, 1'b1, 4'hC, 8'd6, 4'd0, 8'h0C, 4'hC, 1'b1, 1'b0);
    add(6, 1'b0, 1'b1, 4'hC, 8'd6, 4'd0, 8'hC0, 4'hC, 1'b1, 1'b0);
    add(1, 1'b0, 1'b1, 4'hC, 8'd6, 4'd0, 8'h0C, 4'hC, 1'b1, 1'b1);
    add(5, 1'b0, 1'b1, 4'hC, 8'd6, 4'd0, 8'h0C, 4'hC, 1'b1, 1'b0);
    add(3, 1'b0, 1'b1, 4'hC, 8'd6, 4'd0, 8'hC0, 4'hC, 1'b1, 1'b0);
    // Reset in the middle of DRIVE_B, then stay idle
    add(1, 1'b1, 1'b1, 4'hC, 8'd6, 4'd0, 8'h00, 4'h0, 1'b0, 1'b0);
    add(2, 1'b0, 1'b0, 4'hC, 8'd6, 4'd0, 8'h00, 4'h0, 1'b0, 1'b0);

    for (int i = 0; i < nvec; i++) begin
      rst         = vec[i].r;
      enable      = vec[i].en;
      state       = vec[i].st;
      half_period = vec[i].hp;
      dead_time   = vec[i].dt;
      @(posedge clk);
      #1;
      check("vec", i, {14'd0, fets, active_state, running, period_start},
            {14'd0, vec[i].f, vec[i].a, vec[i].run, vec[i].ps});
    end

    // Random soak: phase overlap never occurs and each period lasts 2*H
    in_period = 1'b0;
    cnt       = 0;
    hlat      = 0;
    for (int c = 0; c < 10000; c++) begin
      rst         = 1'b0;
      enable      = ($urandom_range(0, 15) != 0);
      state       = 4'($urandom_range(0, 15));
      half_period = 8'($urandom_range(0, 12));
      dead_time   = 4'($urandom_range(0, 15));
      hv          = (half_period < 8'd2) ? 2 : int'(half_period);
      @(posedge clk);
      #1;
      check("overlap", c, {24'd0, fets[3:0] & fets[7:4]}, 32'd0);
      if (period_start) begin
        if (in_period) check("period_len", c, cnt, 2 * hlat);
        hlat      = hv;
        cnt       = 1;
        in_period = 1'b1;
      end else if (in_period && running) begin
        cnt++;
      end else if (in_period) begin
        check("period_len_end", c, cnt, 2 * hlat);
        in_period = 1'b0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cap_bank_pushpull_driver.md
Name: cap_bank_pushpull_driver

Overview:
Parametrised successor to the cap-board MOSFET driver. Generates the push-pull square-wave drive for N capacitor banks from the system clock, using an internal programmable divider. It inserts programmable dead time between phases and applies bank-state changes only on full-period boundaries, so every transformer sees whole, volt-second-balanced cycles. It sits between the board-state register and the MIC4427 gate-driver pins.

Parameters:
N_BANKS, 4, number of capacitor banks (one push-pull FET pair each)
DIV_W, 8, width of half-period count (clk cycles per half period)
DEAD_W, 4, width of dead-time count (clk cycles)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
enable  input  1  run request; drive runs while high
state  input  N_BANKS  requested bank on/off, bit i = bank i
half_period  input  DIV_W  clk cycles per half period H; values <2 treated as 2
dead_time  input  DEAD_W  dead-time cycles D at start of each half period
fets  output  2*N_BANKS  [N-1:0] phase A gates, [2N-1:N] phase B gates (bit i+N pairs with bit i)
active_state  output  N_BANKS  bank mask currently being driven
running  output  1  high while FSM not IDLE
period_start  output  1  one-cycle pulse on first cycle of each DEAD_A

Behaviour:
- Reset (rst=1 at a clk edge): FSM=IDLE, fets=0, active_state=0, running=0, period_start=0, counters=0. Reset overrides all, including mid-period: outputs low next cycle, no completion of the period.
- All outputs registered. Invariant: fets[i] & fets[i+N] == 0 on every cycle for every i.
- FSM states: IDLE, DEAD_A, DRIVE_A, DEAD_B, DRIVE_B.
- IDLE: fets=0. When enable=1, go to DEAD_A next cycle.
- Period-start latch (entry into DEAD_A): sample state->active_state, H=max(half_period,2), Deff=min(dead_time,H-1), and assert period_start for that cycle. Changes to state/half_period/dead_time during a period are ignored until the next DEAD_A.
- DEAD_A: Deff cycles, fets=0 (if Deff=0, skip directly to DRIVE_A with no dead cycles).
- DRIVE_A: H-Deff cycles, fets[N-1:0]=active_state, fets[2N-1:N]=0.
- DEAD_B: Deff cycles, fets=0.
- DRIVE_B: H-Deff cycles, fets[2N-1:N]=active_state, fets[N-1:0]=0.
- End of DRIVE_B: if enable=1, go to DEAD_A (new latch). Otherwise go to IDLE, clear active_state, and deassert running.
- enable falling mid-period: the current period always completes through DRIVE_B, so no half-cycle is left on the transformer. enable rising again before the period ends: no effect; the period continues normally.
- Full period = 2*H clk cycles exactly; one counter of DIV_W bits counts within each sub-state, reloaded on each transition.
- active_state=0 with enable=1: FSM still cycles and period_start pulses; fets stay 0.
- running=1 in all states except IDLE.

Decomposition:
- Shared package cap_board_pkg: FSM state encoding (3-bit localparams), defaults for N_BANKS/DIV_W/DEAD_W, MIN_HALF_PERIOD=2.
- One natural sub-module: cap_phase_timer. It holds the down-counter with load/terminal-count and sequences the sub-state durations (Deff, H-Deff). The top level holds the FSM, the latch registers and the output gating.

Test Plan:
- Reset/idle: rst=1 for 3 cycles, enable=1, state=4'b1111 -> fets=0, running=0, active_state=0 throughout reset; first DEAD_A on the cycle after rst falls.
- Basic waveform: H=10, D=2, state=4'b0101, enable=1 -> repeating 20-cycle period. fets=0 for 2 cycles, then fets=8'h05 for 8, then 0 for 2, then 8'h50 for 8. period_start every 20 cycles.
- Mid-period state change: change state 4'b0101->4'b0011 at cycle 5 of a period -> remainder of that period unchanged. Next period drives 8'h03/8'h30. No partial phase.
- Disable mid-period: drop enable during DRIVE_A -> DEAD_B and DRIVE_B still complete. Then IDLE, fets=0, running=0, active_state=0.
- Clamping: half_period=1, dead_time=15 -> H=2, Deff=1, giving a 4-cycle period of pattern 0,A,0,B. half_period=6, dead_time=0 -> no dead cycles, 6 cycles A then 6 cycles B.
- Reset mid-drive plus random soak: assert rst during DRIVE_B -> fets=0 next cycle. Then run 10k random cycles of state/enable/H/D -> assertion fets[i]&fets[i+4]==0 never fires, and every period length equals 2*H of its latched H.
